fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter NUM_REQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameters C_OP 32, C_CMD 4, C_RM 3, C_TAG 5, C_FLAG 9: operand, command, rounding-mode, requester-tag and flag widths.
REQ-003 SHALL derive C_ID = clog2(NUM_REQ) and C_FTAG = C_TAG + C_ID (FPU-side tag width).

Ports (name, direction, width, meaning):
REQ-004 SHALL have Clk_CI, in, 1, the single clock. All logic is clocked on its rising edge.
REQ-005 SHALL have Rst_RI, in, 1, reset. It is synchronous and active-high.
REQ-006 SHALL have req_valid_SI, in, NUM_REQ; req_ready_SO, out, NUM_REQ: per-requester issue handshake.
REQ-007 SHALL have req_arga_DI and req_argb_DI, in, NUM_REQ*C_OP; req_op_DI, in, NUM_REQ*C_CMD; req_rm_DI, in, NUM_REQ*C_RM; req_tag_DI, in, NUM_REQ*C_TAG: flattened per-requester payload, requester i at slice i.
REQ-008 SHALL have resp_valid_SO, out, NUM_REQ; resp_ready_SI, in, NUM_REQ; resp_result_DO, out, C_OP; resp_flags_DO, out, C_FLAG; resp_tag_DO, out, C_TAG: per-requester response handshake and a shared response payload.
REQ-009 SHALL have fpu_valid_SO, out, 1; fpu_arga_DO/fpu_argb_DO, out, C_OP; fpu_op_DO, out, C_CMD; fpu_rm_DO, out, C_RM; fpu_tag_DO, out, C_FTAG: issue side to the shared FPU, which is always ready.
REQ-010 SHALL have fpu_rvalid_SI, in, 1; fpu_result_DI, in, C_OP; fpu_flags_DI, in, C_FLAG; fpu_rtag_DI, in, C_FTAG: FPU response.
REQ-011 SHALL have drop_err_SO, out, 1, sticky flag for a dropped FPU response.

Function
REQ-012 SHALL mark requester i eligible when req_valid_SI[i] is high and busy[i] is low.
REQ-013 SHALL grant at most one eligible requester per cycle, round-robin, with search starting at last_grant+1 modulo NUM_REQ.
REQ-014 SHALL assert req_ready_SO[i] combinationally only for the granted requester. The handshake completes in that cycle.
REQ-015 SHALL register the granted payload onto the fpu_* outputs with fpu_valid_SO high in the next cycle, for exactly one cycle. fpu_tag_DO is {grant_id, req_tag}.
REQ-016 SHALL set busy[i] and update last_grant on the grant cycle. At most one operation per requester is ever in flight.
REQ-017 SHALL, on fpu_rvalid_SI, decode id = fpu_rtag_DI[C_FTAG-1:C_TAG]. If busy[id] is high and buffer[id] is empty, it SHALL store result, flags and low tag bits into buffer[id].
REQ-018 SHALL raise resp_valid_SO[id] in the cycle after the FPU response, and hold it until resp_ready_SI[id] is high.
REQ-019 SHALL drive resp_result_DO, resp_flags_DO and resp_tag_DO from the lowest-index requester whose buffer is full. These outputs are zero when no buffer is full.
REQ-020 SHALL allow only that selected requester to see resp_valid_SO high in a given cycle.
REQ-021 SHALL, on response acceptance (resp_valid_SO[i] and resp_ready_SI[i] both high), empty buffer[i] and clear busy[i]. Requester i becomes eligible in the following cycle, not the same cycle.
REQ-022 SHALL discard an FPU response when its id >= NUM_REQ, when busy[id] is low, or when buffer[id] is full. On a discard it SHALL set drop_err_SO, which is cleared only by reset.
REQ-023 SHALL keep the grant and response paths independent when a grant and an FPU response occur in the same cycle.
REQ-024 SHALL drive no grant and keep fpu_valid_SO low in the next cycle when no requester is eligible.

Reset
REQ-025 SHALL, while Rst_RI is high at a clock edge, clear busy, the buffers, last_grant (to NUM_REQ-1, so requester 0 is first), fpu_valid_SO, the fpu_* payload registers and drop_err_SO.
REQ-026 SHALL hold req_ready_SO and resp_valid_SO low during reset.
REQ-027 SHALL treat an FPU response that arrives after a reset in the middle of an operation as a discard under REQ-022.

Structure
REQ-028 SHALL take C_OP, C_CMD, C_RM, C_TAG and C_FLAG from the shared FPU package. NUM_REQ stays a module parameter.
REQ-029 SHALL implement the round-robin search as one sub-module, rr_arbiter (inputs: request vector and last_grant; outputs: one-hot grant, grant_id and any_grant).

Verification
REQ-030 Single requester: req0 issues op=ADD, tag=5. Required: ready0 in the same cycle; fpu_valid next cycle with fpu_tag={0,5}; FPU response -> resp_valid0 the following cycle with tag 5.
REQ-031 All 4 requesters valid continuously, FPU latency 2, resp_ready always high. Required: grants in order 0,1,2,3,0,... with no requester granted twice before all others are served.
REQ-032 Backpressure: req1 response held with resp_ready1=0 for 10 cycles. Required: resp_valid1 and payload stable throughout; req1 never re-granted until one cycle after acceptance.
REQ-033 Same-cycle events: grant to req2 while the FPU response for req0 arrives. Required: both handled, fpu_valid next cycle, resp_valid0 next cycle.
REQ-034 Reset mid-operation: grant req3, assert Rst_RI for 1 cycle, then inject the FPU response with id 3. Required: response discarded, drop_err_SO=1, resp_valid all low.
REQ-035 Response priority: buffers 1 and 2 full simultaneously. Required: resp_valid2 stays low until req1 is accepted.

Source files
------------

// File: rtl/fpu_arbiter_pkg.sv
// Shared FPU widths and opcode encoding used by the
// multi-requester FPU arbiter and its clients.
package fpu_arbiter_pkg;

   localparam int unsigned C_OP   = 32;
   localparam int unsigned C_CMD  = 4;
   localparam int unsigned C_RM   = 3;
   localparam int unsigned C_TAG  = 5;
   localparam int unsigned C_FLAG = 9;

   typedef enum logic [C_CMD-1:0] {
      FPU_ADD  = 4'd0,
      FPU_SUB  = 4'd1,
      FPU_MUL  = 4'd2,
      FPU_DIV  = 4'd3,
      FPU_SQRT = 4'd4
   } fpu_cmd_e;

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Round-robin pick among request lines, searching from
// the slot after the previous winner.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned C_ID    = 2
) (
   input  logic [NUM_REQ-1:0] req_SI,
   input  logic [C_ID-1:0]    last_grant_DI,
   output logic [NUM_REQ-1:0] gnt_SO,
   output logic [C_ID-1:0]    gnt_id_DO,
   output logic               any_gnt_SO
);

   logic [C_ID-1:0] idx;

   always_comb begin
      gnt_SO     = '0;
      gnt_id_DO  = '0;
      any_gnt_SO = 1'b0;
      idx        = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         idx = C_ID'((int'(last_grant_DI) + k) % int'(NUM_REQ));
         if (!any_gnt_SO && req_SI[idx]) begin
            any_gnt_SO  = 1'b1;
            gnt_SO[idx] = 1'b1;
            gnt_id_DO   = idx;
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one always-ready FPU among NUM_REQ requesters,
// one op in flight per requester, buffered responses.
module fpu_arbiter
   import fpu_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned C_ID    = $clog2(NUM_REQ),
   localparam int unsigned C_FTAG  = C_TAG + C_ID
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RI,
   input  logic [NUM_REQ-1:0]        req_valid_SI,
   output logic [NUM_REQ-1:0]        req_ready_SO,
   input  logic [NUM_REQ*C_OP-1:0]   req_arga_DI,
   input  logic [NUM_REQ*C_OP-1:0]   req_argb_DI,
   input  logic [NUM_REQ*C_CMD-1:0]  req_op_DI,
   input  logic [NUM_REQ*C_RM-1:0]   req_rm_DI,
   input  logic [NUM_REQ*C_TAG-1:0]  req_tag_DI,
   output logic [NUM_REQ-1:0]        resp_valid_SO,
   input  logic [NUM_REQ-1:0]        resp_ready_SI,
   output logic [C_OP-1:0]           resp_result_DO,
   output logic [C_FLAG-1:0]         resp_flags_DO,
   output logic [C_TAG-1:0]          resp_tag_DO,
   output logic                      fpu_valid_SO,
   output logic [C_OP-1:0]           fpu_arga_DO,
   output logic [C_OP-1:0]           fpu_argb_DO,
   output logic [C_CMD-1:0]          fpu_op_DO,
   output logic [C_RM-1:0]           fpu_rm_DO,
   output logic [C_FTAG-1:0]         fpu_tag_DO,
   input  logic                      fpu_rvalid_SI,
   input  logic [C_OP-1:0]           fpu_result_DI,
   input  logic [C_FLAG-1:0]         fpu_flags_DI,
   input  logic [C_FTAG-1:0]         fpu_rtag_DI,
   output logic                      drop_err_SO
);

   logic [NUM_REQ-1:0] busy_q, full_q, elig, gnt;
   logic [NUM_REQ-1:0] rsp_hit, wr, acc, sel;
   logic [C_ID-1:0]    last_q, gnt_id, rsp_id;
   logic               any_gnt;

   logic [C_OP-1:0]    g_arga, g_argb;
   logic [C_CMD-1:0]   g_op;
   logic [C_RM-1:0]    g_rm;
   logic [C_TAG-1:0]   g_tag;

   logic [C_OP-1:0]    res_q [NUM_REQ];
   logic [C_FLAG-1:0]  flg_q [NUM_REQ];
   logic [C_TAG-1:0]   tag_q [NUM_REQ];

   assign elig = req_valid_SI & ~busy_q;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .C_ID    (C_ID)
   ) i_rr (
      .req_SI        (elig),
      .last_grant_DI (last_q),
      .gnt_SO        (gnt),
      .gnt_id_DO     (gnt_id),
      .any_gnt_SO    (any_gnt)
   );

   assign req_ready_SO = gnt & {NUM_REQ{~Rst_RI}};

   always_comb begin
      g_arga = '0;
      g_argb = '0;
      g_op   = '0;
      g_rm   = '0;
      g_tag  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gnt[i]) begin
            g_arga = req_arga_DI[i*C_OP +: C_OP];
            g_argb = req_argb_DI[i*C_OP +: C_OP];
            g_op   = req_op_DI[i*C_CMD +: C_CMD];
            g_rm   = req_rm_DI[i*C_RM +: C_RM];
            g_tag  = req_tag_DI[i*C_TAG +: C_TAG];
         end
      end
   end

   // ids beyond NUM_REQ never match a slot and fall out as drops
   assign rsp_id = fpu_rtag_DI[C_FTAG-1:C_TAG];

   always_comb begin
      rsp_hit = '0;
      sel     = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         rsp_hit[i] = fpu_rvalid_SI && (rsp_id == C_ID'(i));
         if (full_q[i] && sel == '0) sel[i] = 1'b1;
      end
   end

   assign wr            = rsp_hit & busy_q & ~full_q;
   assign resp_valid_SO = sel & {NUM_REQ{~Rst_RI}};
   assign acc           = resp_valid_SO & resp_ready_SI;

   always_comb begin
      resp_result_DO = '0;
      resp_flags_DO  = '0;
      resp_tag_DO    = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (sel[i]) begin
            resp_result_DO = res_q[i];
            resp_flags_DO  = flg_q[i];
            resp_tag_DO    = tag_q[i];
         end
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         busy_q       <= '0;
         full_q       <= '0;
         last_q       <= C_ID'(NUM_REQ - 1);
         fpu_valid_SO <= 1'b0;
         fpu_arga_DO  <= '0;
         fpu_argb_DO  <= '0;
         fpu_op_DO    <= '0;
         fpu_rm_DO    <= '0;
         fpu_tag_DO   <= '0;
         drop_err_SO  <= 1'b0;
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            res_q[i] <= '0;
            flg_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         fpu_valid_SO <= any_gnt;
         if (any_gnt) begin
            last_q      <= gnt_id;
            fpu_arga_DO <= g_arga;
            fpu_argb_DO <= g_argb;
            fpu_op_DO   <= g_op;
            fpu_rm_DO   <= g_rm;
            fpu_tag_DO  <= {gnt_id, g_tag};
         end
         busy_q <= (busy_q | gnt) & ~acc;
         full_q <= (full_q | wr) & ~acc;
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (wr[i]) begin
               res_q[i] <= fpu_result_DI;
               flg_q[i] <= fpu_flags_DI;
               tag_q[i] <= fpu_rtag_DI[C_TAG-1:0];
            end
         end
         if (fpu_rvalid_SI && wr == '0) drop_err_SO <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scenario bench for fpu_arbiter with a queue-based
// scoreboard for FPU issues and responses.
module tb_fpu_arbiter;
   import fpu_arbiter_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned CI = 2;
   localparam int unsigned CF = C_TAG + CI;

   logic              Clk_CI, Rst_RI;
   logic [N-1:0]      req_valid_SI, req_ready_SO;
   logic [N*C_OP-1:0] req_arga_DI, req_argb_DI;
   logic [N*C_CMD-1:0] req_op_DI;
   logic [N*C_RM-1:0] req_rm_DI;
   logic [N*C_TAG-1:0] req_tag_DI;
   logic [N-1:0]      resp_valid_SO, resp_ready_SI;
   logic [C_OP-1:0]   resp_result_DO;
   logic [C_FLAG-1:0] resp_flags_DO;
   logic [C_TAG-1:0]  resp_tag_DO;
   logic              fpu_valid_SO;
   logic [C_OP-1:0]   fpu_arga_DO, fpu_argb_DO;
   logic [C_CMD-1:0]  fpu_op_DO;
   logic [C_RM-1:0]   fpu_rm_DO;
   logic [CF-1:0]     fpu_tag_DO;
   logic              fpu_rvalid_SI;
   logic [C_OP-1:0]   fpu_result_DI;
   logic [C_FLAG-1:0] fpu_flags_DI;
   logic [CF-1:0]     fpu_rtag_DI;
   logic              drop_err_SO;

   typedef struct {
      logic [CF-1:0]   tag;
      logic [C_OP-1:0] arga;
      logic [C_OP-1:0] argb;
   } iss_t;

   typedef struct {
      int unsigned       id;
      logic [C_OP-1:0]   res;
      logic [C_FLAG-1:0] flg;
      logic [C_TAG-1:0]  tag;
   } rsp_t;

   typedef struct {
      int            due;
      logic [CF-1:0] tag;
   } pend_t;

   iss_t  iss_q[$];
   rsp_t  rsp_q[$];
   pend_t pend_q[$];
   int    vec, err;

   fpu_arbiter #(.NUM_REQ(N)) dut (
      .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
      .req_valid_SI(req_valid_SI), .req_ready_SO(req_ready_SO),
      .req_arga_DI(req_arga_DI), .req_argb_DI(req_argb_DI),
      .req_op_DI(req_op_DI), .req_rm_DI(req_rm_DI),
      .req_tag_DI(req_tag_DI),
      .resp_valid_SO(resp_valid_SO), .resp_ready_SI(resp_ready_SI),
      .resp_result_DO(resp_result_DO), .resp_flags_DO(resp_flags_DO),
      .resp_tag_DO(resp_tag_DO),
      .fpu_valid_SO(fpu_valid_SO),
      .fpu_arga_DO(fpu_arga_DO), .fpu_argb_DO(fpu_argb_DO),
      .fpu_op_DO(fpu_op_DO), .fpu_rm_DO(fpu_rm_DO),
      .fpu_tag_DO(fpu_tag_DO),
      .fpu_rvalid_SI(fpu_rvalid_SI), .fpu_result_DI(fpu_result_DI),
      .fpu_flags_DI(fpu_flags_DI), .fpu_rtag_DI(fpu_rtag_DI),
      .drop_err_SO(drop_err_SO)
   );

   initial Clk_CI = 1'b0;
   always #5 Clk_CI = ~Clk_CI;

   function automatic logic [C_TAG-1:0] tag_of(int i);
      return C_TAG'(5 + i);
   endfunction

   function automatic logic [CF-1:0] ftag_of(int i);
      return {CI'(i), tag_of(i)};
   endfunction

   function automatic logic [C_OP-1:0] arga_of(int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   function automatic logic [C_OP-1:0] argb_of(int i);
      return 32'h2000_0000 + 32'(i * 16);
   endfunction

   function automatic logic [C_OP-1:0] res_of(logic [CF-1:0] t);
      return 32'hC000_0000 | 32'(t);
   endfunction

   function automatic logic [C_FLAG-1:0] flg_of(logic [CF-1:0] t);
      return C_FLAG'(t) ^ 9'h155;
   endfunction

   function automatic logic [N-1:0] oh(int unsigned i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge Clk_CI);
      #1;
   endtask

   task automatic drive_rsp(logic [CF-1:0] t);
      fpu_rvalid_SI = 1'b1;
      fpu_rtag_DI   = t;
      fpu_result_DI = res_of(t);
      fpu_flags_DI  = flg_of(t);
   endtask

   task automatic do_reset();
      Rst_RI        = 1'b1;
      req_valid_SI  = '0;
      resp_ready_SI = '0;
      fpu_rvalid_SI = 1'b0;
      iss_q.delete();
      rsp_q.delete();
      pend_q.delete();
      tick();
      tick();
      Rst_RI = 1'b0;
   endtask

   task automatic test_reset();
      Rst_RI        = 1'b1;
      req_valid_SI  = '1;
      resp_ready_SI = '1;
      fpu_rvalid_SI = 1'b0;
      tick();
      tick();
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== '0) begin
         err++;
         $display("FAIL rst_ready: got %b want 0", req_ready_SO);
      end
      vec++;
      if (resp_valid_SO !== '0 || fpu_valid_SO !== 1'b0) begin
         err++;
         $display("FAIL rst_valid: resp %b fpu %b want 0",
                  resp_valid_SO, fpu_valid_SO);
      end
      vec++;
      if (drop_err_SO !== 1'b0 || resp_result_DO !== '0) begin
         err++;
         $display("FAIL rst_state: drop %b res %h want 0",
                  drop_err_SO, resp_result_DO);
      end
      tick();
      Rst_RI        = 1'b0;
      req_valid_SI  = '0;
      resp_ready_SI = '0;
      @(negedge Clk_CI);
      vec++;
      if (fpu_valid_SO !== 1'b0 || req_ready_SO !== '0) begin
         err++;
         $display("FAIL rst_idle: fpu %b ready %b want 0",
                  fpu_valid_SO, req_ready_SO);
      end
   endtask

   task automatic test_single();
      iss_t e;
      rsp_t r;
      do_reset();
      req_valid_SI = 4'b0001;
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0001) begin
         err++;
         $display("FAIL single_ready: got %b want 0001", req_ready_SO);
      end
      iss_q.push_back('{ftag_of(0), arga_of(0), argb_of(0)});
      tick();
      req_valid_SI = '0;
      @(negedge Clk_CI);
      e = iss_q.pop_front();
      vec++;
      if (fpu_valid_SO !== 1'b1 || fpu_tag_DO !== e.tag) begin
         err++;
         $display("FAIL single_issue: valid %b tag %h want 1 %h",
                  fpu_valid_SO, fpu_tag_DO, e.tag);
      end
      vec++;
      if (fpu_arga_DO !== e.arga || fpu_argb_DO !== e.argb ||
          fpu_op_DO !== FPU_ADD) begin
         err++;
         $display("FAIL single_payload: a %h b %h op %h want %h %h %h",
                  fpu_arga_DO, fpu_argb_DO, fpu_op_DO,
                  e.arga, e.argb, FPU_ADD);
      end
      tick();
      drive_rsp(e.tag);
      rsp_q.push_back('{0, res_of(e.tag), flg_of(e.tag), tag_of(0)});
      @(negedge Clk_CI);
      vec++;
      if (fpu_valid_SO !== 1'b0 || resp_valid_SO !== '0) begin
         err++;
         $display("FAIL single_pulse: fpu %b resp %b want 0 0",
                  fpu_valid_SO, resp_valid_SO);
      end
      tick();
      fpu_rvalid_SI = 1'b0;
      @(negedge Clk_CI);
      r = rsp_q.pop_front();
      vec++;
      if (resp_valid_SO !== oh(r.id) || resp_result_DO !== r.res ||
          resp_flags_DO !== r.flg || resp_tag_DO !== r.tag) begin
         err++;
         $display("FAIL single_resp: v %b r %h f %h t %h want %b %h %h %h",
                  resp_valid_SO, resp_result_DO, resp_flags_DO,
                  resp_tag_DO, oh(r.id), r.res, r.flg, r.tag);
      end
      tick();
      resp_ready_SI = 4'b0001;
      tick();
      resp_ready_SI = '0;
      @(negedge Clk_CI);
      vec++;
      if (resp_valid_SO !== '0 || drop_err_SO !== 1'b0) begin
         err++;
         $display("FAIL single_done: resp %b drop %b want 0 0",
                  resp_valid_SO, drop_err_SO);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      req_valid_SI = 4'b0010;
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0010) begin
         err++;
         $display("FAIL rr_first: got %b want 0010", req_ready_SO);
      end
      tick();
      req_valid_SI = 4'b0101;
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0100) begin
         err++;
         $display("FAIL rr_wrap: got %b want 0100", req_ready_SO);
      end
      tick();
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0001) begin
         err++;
         $display("FAIL rr_next: got %b want 0001", req_ready_SO);
      end
      tick();
      req_valid_SI = '0;
   endtask

   task automatic test_round_robin();
      iss_t  e;
      rsp_t  r;
      pend_t p;
      int    exp_next, grants;
      do_reset();
      exp_next      = 0;
      grants        = 0;
      req_valid_SI  = '1;
      resp_ready_SI = '1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc == 30) req_valid_SI = '0;
         fpu_rvalid_SI = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            drive_rsp(p.tag);
            rsp_q.push_back('{int'(p.tag[CF-1:C_TAG]), res_of(p.tag),
                              flg_of(p.tag), p.tag[C_TAG-1:0]});
         end
         @(negedge Clk_CI);
         if (req_ready_SO !== '0) begin
            vec++;
            if (req_ready_SO !== oh(exp_next)) begin
               err++;
               $display("FAIL rr_order: got %b want %b",
                        req_ready_SO, oh(exp_next));
            end
            iss_q.push_back('{ftag_of(exp_next), arga_of(exp_next),
                              argb_of(exp_next)});
            exp_next = (exp_next + 1) % N;
            grants++;
         end
         if (fpu_valid_SO === 1'b1) begin
            vec++;
            if (iss_q.size() == 0) begin
               err++;
               $display("FAIL rr_issue: unexpected tag %h", fpu_tag_DO);
            end else begin
               e = iss_q.pop_front();
               if (fpu_tag_DO !== e.tag || fpu_arga_DO !== e.arga) begin
                  err++;
                  $display("FAIL rr_issue: tag %h a %h want %h %h",
                           fpu_tag_DO, fpu_arga_DO, e.tag, e.arga);
               end
               pend_q.push_back('{cyc + 2, e.tag});
            end
         end
         if (resp_valid_SO !== '0) begin
            vec++;
            if (rsp_q.size() == 0) begin
               err++;
               $display("FAIL rr_resp: unexpected valid %b", resp_valid_SO);
            end else begin
               r = rsp_q.pop_front();
               if (resp_valid_SO !== oh(r.id) ||
                   resp_result_DO !== r.res || resp_tag_DO !== r.tag) begin
                  err++;
                  $display("FAIL rr_resp: v %b r %h t %h want %b %h %h",
                           resp_valid_SO, resp_result_DO, resp_tag_DO,
                           oh(r.id), r.res, r.tag);
               end
            end
         end
         tick();
      end
      fpu_rvalid_SI = 1'b0;
      resp_ready_SI = '0;
      vec++;
      if (grants < 16) begin
         err++;
         $display("FAIL rr_count: got %0d grants want >= 16", grants);
      end
      vec++;
      if (iss_q.size() + rsp_q.size() + pend_q.size() != 0) begin
         err++;
         $display("FAIL rr_drain: %0d items left want 0",
                  iss_q.size() + rsp_q.size() + pend_q.size());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid_SI = 4'b0010;
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0010) begin
         err++;
         $display("FAIL bp_grant: got %b want 0010", req_ready_SO);
      end
      tick();
      @(negedge Clk_CI);
      vec++;
      if (fpu_tag_DO !== ftag_of(1) || req_ready_SO !== '0) begin
         err++;
         $display("FAIL bp_issue: tag %h ready %b want %h 0",
                  fpu_tag_DO, req_ready_SO, ftag_of(1));
      end
      tick();
      drive_rsp(ftag_of(1));
      tick();
      fpu_rvalid_SI = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clk_CI);
         vec++;
         if (resp_valid_SO !== 4'b0010 || req_ready_SO !== '0 ||
             resp_result_DO !== res_of(ftag_of(1)) ||
             resp_tag_DO !== tag_of(1)) begin
            err++;
            $display("FAIL bp_hold%0d: v %b rdy %b r %h t %h want 0010 0 %h %h",
                     k, resp_valid_SO, req_ready_SO, resp_result_DO,
                     resp_tag_DO, res_of(ftag_of(1)), tag_of(1));
         end
         tick();
      end
      resp_ready_SI = 4'b0010;
      @(negedge Clk_CI);
      vec++;
      if (resp_valid_SO !== 4'b0010 || req_ready_SO !== '0) begin
         err++;
         $display("FAIL bp_accept: v %b rdy %b want 0010 0000",
                  resp_valid_SO, req_ready_SO);
      end
      tick();
      resp_ready_SI = '0;
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0010 || resp_valid_SO !== '0) begin
         err++;
         $display("FAIL bp_regrant: rdy %b v %b want 0010 0000",
                  req_ready_SO, resp_valid_SO);
      end
      tick();
      req_valid_SI = '0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_valid_SI = 4'b0001;
      tick();
      req_valid_SI = '0;
      tick();
      req_valid_SI = 4'b0100;
      drive_rsp(ftag_of(0));
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0100) begin
         err++;
         $display("FAIL same_grant: got %b want 0100", req_ready_SO);
      end
      tick();
      req_valid_SI  = '0;
      fpu_rvalid_SI = 1'b0;
      resp_ready_SI = 4'b0001;
      @(negedge Clk_CI);
      vec++;
      if (fpu_valid_SO !== 1'b1 || fpu_tag_DO !== ftag_of(2)) begin
         err++;
         $display("FAIL same_issue: v %b tag %h want 1 %h",
                  fpu_valid_SO, fpu_tag_DO, ftag_of(2));
      end
      vec++;
      if (resp_valid_SO !== 4'b0001 ||
          resp_result_DO !== res_of(ftag_of(0))) begin
         err++;
         $display("FAIL same_resp: v %b r %h want 0001 %h",
                  resp_valid_SO, resp_result_DO, res_of(ftag_of(0)));
      end
      tick();
      resp_ready_SI = '0;
      @(negedge Clk_CI);
      vec++;
      if (resp_valid_SO !== '0 || drop_err_SO !== 1'b0) begin
         err++;
         $display("FAIL same_done: v %b drop %b want 0 0",
                  resp_valid_SO, drop_err_SO);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid_SI = 4'b1000;
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b1000) begin
         err++;
         $display("FAIL mid_grant: got %b want 1000", req_ready_SO);
      end
      tick();
      req_valid_SI = '0;
      Rst_RI       = 1'b1;
      tick();
      Rst_RI = 1'b0;
      drive_rsp(ftag_of(3));
      tick();
      fpu_rvalid_SI = 1'b0;
      @(negedge Clk_CI);
      vec++;
      if (drop_err_SO !== 1'b1 || resp_valid_SO !== '0) begin
         err++;
         $display("FAIL mid_drop: drop %b v %b want 1 0000",
                  drop_err_SO, resp_valid_SO);
      end
      tick();
      @(negedge Clk_CI);
      vec++;
      if (drop_err_SO !== 1'b1 || fpu_valid_SO !== 1'b0) begin
         err++;
         $display("FAIL mid_sticky: drop %b fpu %b want 1 0",
                  drop_err_SO, fpu_valid_SO);
      end
   endtask

   task automatic test_priority();
      do_reset();
      req_valid_SI = 4'b0110;
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0010) begin
         err++;
         $display("FAIL pri_g1: got %b want 0010", req_ready_SO);
      end
      tick();
      @(negedge Clk_CI);
      vec++;
      if (req_ready_SO !== 4'b0100) begin
         err++;
         $display("FAIL pri_g2: got %b want 0100", req_ready_SO);
      end
      tick();
      req_valid_SI = '0;
      drive_rsp(ftag_of(1));
      tick();
      drive_rsp(ftag_of(2));
      tick();
      fpu_rvalid_SI = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk_CI);
         vec++;
         if (resp_valid_SO !== 4'b0010 ||
             resp_result_DO !== res_of(ftag_of(1))) begin
            err++;
            $display("FAIL pri_hold%0d: v %b r %h want 0010 %h", k,
                     resp_valid_SO, resp_result_DO, res_of(ftag_of(1)));
         end
         tick();
      end
      // second response to a full slot must be discarded
      fpu_rvalid_SI = 1'b1;
      fpu_rtag_DI   = ftag_of(1);
      fpu_result_DI = 32'hDEAD_BEEF;
      fpu_flags_DI  = '1;
      tick();
      fpu_rvalid_SI = 1'b0;
      @(negedge Clk_CI);
      vec++;
      if (drop_err_SO !== 1'b1 ||
          resp_result_DO !== res_of(ftag_of(1))) begin
         err++;
         $display("FAIL pri_dup: drop %b r %h want 1 %h",
                  drop_err_SO, resp_result_DO, res_of(ftag_of(1)));
      end
      tick();
      resp_ready_SI = 4'b0110;
      @(negedge Clk_CI);
      vec++;
      if (resp_valid_SO !== 4'b0010) begin
         err++;
         $display("FAIL pri_sel: got %b want 0010", resp_valid_SO);
      end
      tick();
      resp_ready_SI = '0;
      @(negedge Clk_CI);
      vec++;
      if (resp_valid_SO !== 4'b0100 ||
          resp_result_DO !== res_of(ftag_of(2)) ||
          resp_tag_DO !== tag_of(2)) begin
         err++;
         $display("FAIL pri_next: v %b r %h t %h want 0100 %h %h",
                  resp_valid_SO, resp_result_DO, resp_tag_DO,
                  res_of(ftag_of(2)), tag_of(2));
      end
      tick();
      resp_ready_SI = 4'b0100;
      tick();
      resp_ready_SI = '0;
      @(negedge Clk_CI);
      vec++;
      if (resp_valid_SO !== '0 || resp_result_DO !== '0 ||
          resp_tag_DO !== '0) begin
         err++;
         $display("FAIL pri_empty: v %b r %h t %h want 0 0 0",
                  resp_valid_SO, resp_result_DO, resp_tag_DO);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec           = 0;
      err           = 0;
      fpu_rtag_DI   = '0;
      fpu_result_DI = '0;
      fpu_flags_DI  = '0;
      for (int i = 0; i < int'(N); i++) begin
         req_arga_DI[i*C_OP +: C_OP]  = arga_of(i);
         req_argb_DI[i*C_OP +: C_OP]  = argb_of(i);
         req_op_DI[i*C_CMD +: C_CMD]  = C_CMD'(i);
         req_rm_DI[i*C_RM +: C_RM]    = C_RM'(i);
         req_tag_DI[i*C_TAG +: C_TAG] = tag_of(i);
      end
      test_reset();
      test_single();
      test_fairness();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
